// File: rtl/ariane_pkg.sv
// ariane_pkg: store buffer entry layout, default queue depths and an entry-width helper.
package ariane_pkg;

    localparam int unsigned SB_PLEN         = 56;
    localparam int unsigned SB_XLEN         = 64;
    localparam int unsigned SB_SPEC_DEPTH   = 4;
    localparam int unsigned SB_COMMIT_DEPTH = 8;

    typedef struct packed {
        logic [SB_PLEN-1:0]   paddr;
        logic [SB_XLEN-1:0]   data;
        logic [SB_XLEN/8-1:0] be;
        logic [1:0]           size;
        logic                 valid;
    } sb_entry_t;

    // Flattened width of one entry for arbitrary PLEN/XLEN.
    function automatic int unsigned sb_entry_w(input int unsigned plen, input int unsigned xlen);
        return plen + xlen + xlen / 8 + 3;
    endfunction

endpackage

// File: rtl/sb_fwd_lookup.sv
// sb_fwd_lookup: age-ordered load search over commit then speculative entries.
// STORE_BUFFER_FWD_EN builds the youngest-overlap forwarding path; otherwise any index match stalls.
module sb_fwd_lookup import ariane_pkg::*; #(
    parameter int unsigned  SPEC_DEPTH   = SB_SPEC_DEPTH,
    parameter int unsigned  COMMIT_DEPTH = SB_COMMIT_DEPTH,
    parameter int unsigned  PLEN         = SB_PLEN,
    parameter int unsigned  XLEN         = SB_XLEN,
    localparam int unsigned BE_W         = XLEN / 8,
    localparam int unsigned EW           = sb_entry_w(PLEN, XLEN),
    localparam int unsigned SPW          = $clog2(SPEC_DEPTH),
    localparam int unsigned CPW          = $clog2(COMMIT_DEPTH)
) (
    input  logic [COMMIT_DEPTH*EW-1:0] commit_q,
    input  logic [CPW-1:0]             commit_head,
    input  logic [SPEC_DEPTH*EW-1:0]   spec_q,
    input  logic [SPW-1:0]             spec_head,
    input  logic                       ld_valid,
    input  logic [PLEN-1:0]            ld_paddr,
    input  logic [BE_W-1:0]            ld_be,
    input  logic                       push_valid,
    input  logic [8:0]                 push_idx,
    output logic                       hit,
    output logic [XLEN-1:0]            data,
    output logic                       conflict
);

    typedef struct packed {
        logic [PLEN-1:0] paddr;
        logic [XLEN-1:0] data;
        logic [BE_W-1:0] be;
        logic [1:0]      size;
        logic            valid;
    } entry_t;

    entry_t [COMMIT_DEPTH-1:0] cq;
    entry_t [SPEC_DEPTH-1:0]   sq;
    logic                      idx_match;
    logic                      unused_bits;

    assign cq          = commit_q;
    assign sq          = spec_q;
    assign unused_bits = ^{cq, sq, ld_be, ld_paddr, commit_head, spec_head};

    always_comb begin
        idx_match = push_valid && push_idx == ld_paddr[11:3];
        for (int k = 0; k < COMMIT_DEPTH; k++)
            idx_match |= cq[k].valid && cq[k].paddr[11:3] == ld_paddr[11:3];
        for (int k = 0; k < SPEC_DEPTH; k++)
            idx_match |= sq[k].valid && sq[k].paddr[11:3] == ld_paddr[11:3];
    end

`ifdef STORE_BUFFER_FWD_EN
    logic   found;
    entry_t young;
    entry_t e;

    // Walk oldest to youngest so the last overlapping entry wins.
    always_comb begin
        found = 1'b0;
        young = '0;
        e     = '0;
        for (int k = 0; k < COMMIT_DEPTH; k++) begin
            e = cq[commit_head + CPW'(k)];
            if (e.valid && e.paddr[PLEN-1:3] == ld_paddr[PLEN-1:3] && |(e.be & ld_be)) begin
                found = 1'b1;
                young = e;
            end
        end
        for (int k = 0; k < SPEC_DEPTH; k++) begin
            e = sq[spec_head + SPW'(k)];
            if (e.valid && e.paddr[PLEN-1:3] == ld_paddr[PLEN-1:3] && |(e.be & ld_be)) begin
                found = 1'b1;
                young = e;
            end
        end
        hit      = ld_valid && found && ~|(ld_be & ~young.be);
        data     = hit ? young.data : '0;
        conflict = ld_valid && !hit && idx_match;
    end
`else
    assign hit      = 1'b0;
    assign data     = '0;
    assign conflict = ld_valid & idx_match;
`endif

endmodule

// File: rtl/store_buffer_fwd.sv
// store_buffer_fwd: speculative queue feeding an in-order commit FIFO that drains to the D$.
// Store-to-load forwarding is built only when STORE_BUFFER_FWD_EN is defined.
module store_buffer_fwd import ariane_pkg::*; #(
    parameter int unsigned  SPEC_DEPTH   = SB_SPEC_DEPTH,
    parameter int unsigned  COMMIT_DEPTH = SB_COMMIT_DEPTH,
    parameter int unsigned  PLEN         = SB_PLEN,
    parameter int unsigned  XLEN         = SB_XLEN,
    localparam int unsigned BE_W         = XLEN / 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            st_valid_i,
    output logic            st_ready_o,
    input  logic [PLEN-1:0] st_paddr_i,
    input  logic [XLEN-1:0] st_data_i,
    input  logic [BE_W-1:0] st_be_i,
    input  logic [1:0]      st_size_i,
    input  logic            commit_i,
    output logic            commit_ready_o,
    input  logic            ld_valid_i,
    input  logic [PLEN-1:0] ld_paddr_i,
    input  logic [BE_W-1:0] ld_be_i,
    output logic            ld_conflict_o,
    output logic            ld_fwd_hit_o,
    output logic [XLEN-1:0] ld_fwd_data_o,
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic [PLEN-1:0] mem_paddr_o,
    output logic [XLEN-1:0] mem_data_o,
    output logic [BE_W-1:0] mem_be_o,
    output logic [1:0]      mem_size_o,
    output logic            no_st_pending_o,
    output logic            empty_o
);

    localparam int unsigned SPW = $clog2(SPEC_DEPTH);
    localparam int unsigned CPW = $clog2(COMMIT_DEPTH);

    typedef struct packed {
        logic [PLEN-1:0] paddr;
        logic [XLEN-1:0] data;
        logic [BE_W-1:0] be;
        logic [1:0]      size;
        logic            valid;
    } entry_t;

    entry_t [SPEC_DEPTH-1:0]   spec_q;
    entry_t [COMMIT_DEPTH-1:0] commit_q;
    logic [SPW-1:0]            s_rd, s_wr;
    logic [SPW:0]              s_cnt;
    logic [CPW-1:0]            c_rd, c_wr;
    logic [CPW:0]              c_cnt;
    logic                      push, pop;

    // Depths are powers of two, so "count < DEPTH" is just the count MSB being clear.
    assign st_ready_o      = ~s_cnt[SPW];
    assign commit_ready_o  = ~c_cnt[CPW];
    assign push            = st_valid_i & st_ready_o & ~flush_i;
    assign mem_req_o       = |c_cnt;
    assign pop             = mem_req_o & mem_gnt_i;
    assign no_st_pending_o = ~mem_req_o;
    assign empty_o         = no_st_pending_o & ~|s_cnt;
    assign mem_paddr_o     = mem_req_o ? commit_q[c_rd].paddr : '0;
    assign mem_data_o      = mem_req_o ? commit_q[c_rd].data : '0;
    assign mem_be_o        = mem_req_o ? commit_q[c_rd].be : '0;
    assign mem_size_o      = mem_req_o ? commit_q[c_rd].size : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spec_q   <= '0;
            commit_q <= '0;
            s_rd     <= '0;
            s_wr     <= '0;
            s_cnt    <= '0;
            c_rd     <= '0;
            c_wr     <= '0;
            c_cnt    <= '0;
        end else begin
            if (push) begin
                spec_q[s_wr] <= entry_t'{paddr: st_paddr_i, data: st_data_i, be: st_be_i, size: st_size_i, valid: 1'b1};
                s_wr         <= s_wr + SPW'(1);
            end
            if (commit_i) begin
                commit_q[c_wr]     <= spec_q[s_rd];
                spec_q[s_rd].valid <= 1'b0;
                s_rd               <= s_rd + SPW'(1);
                c_wr               <= c_wr + CPW'(1);
            end
            if (pop) begin
                commit_q[c_rd].valid <= 1'b0;
                c_rd                 <= c_rd + CPW'(1);
            end
            c_cnt <= c_cnt + (CPW+1)'(commit_i) - (CPW+1)'(pop);
            s_cnt <= flush_i ? '0 : s_cnt + (SPW+1)'(push) - (SPW+1)'(commit_i);
            // Flush keeps a same-cycle commit, so the write pointer lands past it.
            if (flush_i) begin
                s_wr <= s_rd + SPW'(commit_i);
                for (int i = 0; i < SPEC_DEPTH; i++)
                    spec_q[i].valid <= 1'b0;
            end
        end
    end

    sb_fwd_lookup #(
        .SPEC_DEPTH   (SPEC_DEPTH),
        .COMMIT_DEPTH (COMMIT_DEPTH),
        .PLEN         (PLEN),
        .XLEN         (XLEN)
    ) i_lookup (
        .commit_q    (commit_q),
        .commit_head (c_rd),
        .spec_q      (spec_q),
        .spec_head   (s_rd),
        .ld_valid    (ld_valid_i),
        .ld_paddr    (ld_paddr_i),
        .ld_be       (ld_be_i),
        .push_valid  (st_valid_i & st_ready_o),
        .push_idx    (st_paddr_i[11:3]),
        .hit         (ld_fwd_hit_o),
        .data        (ld_fwd_data_o),
        .conflict    (ld_conflict_o)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(st_valid_i && !st_ready_o)) else $error("store pushed while speculative queue full");
            assert (!(commit_i && s_cnt == '0)) else $error("commit with empty speculative queue");
            assert (!(commit_i && !commit_ready_o)) else $error("commit with full commit queue");
        end
    end
`endif

endmodule

// File: tb/tb_store_buffer_fwd.sv
// tb_store_buffer_fwd: table-driven load lookups plus drain, wrap, flush and reset sequences.
// Expectations follow STORE_BUFFER_FWD_EN: without it every would-be hit becomes a conflict.
module tb_store_buffer_fwd;

`ifdef STORE_BUFFER_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, st_valid_i, commit_i, ld_valid_i, mem_gnt_i;
    logic        st_ready_o, commit_ready_o, ld_conflict_o, ld_fwd_hit_o;
    logic        mem_req_o, no_st_pending_o, empty_o;
    logic [55:0] st_paddr_i, ld_paddr_i, mem_paddr_o;
    logic [63:0] st_data_i, ld_fwd_data_o, mem_data_o;
    logic [7:0]  st_be_i, ld_be_i, mem_be_o;
    logic [1:0]  st_size_i, mem_size_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        v;
        logic [55:0] addr;
        logic [7:0]  be;
        logic        conf;
        logic        hit;
        logic [63:0] data;
    } vec_t;

    vec_t vecs[6];

    always #5 clk_i = ~clk_i;

    store_buffer_fwd dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .st_valid_i      (st_valid_i),
        .st_ready_o      (st_ready_o),
        .st_paddr_i      (st_paddr_i),
        .st_data_i       (st_data_i),
        .st_be_i         (st_be_i),
        .st_size_i       (st_size_i),
        .commit_i        (commit_i),
        .commit_ready_o  (commit_ready_o),
        .ld_valid_i      (ld_valid_i),
        .ld_paddr_i      (ld_paddr_i),
        .ld_be_i         (ld_be_i),
        .ld_conflict_o   (ld_conflict_o),
        .ld_fwd_hit_o    (ld_fwd_hit_o),
        .ld_fwd_data_o   (ld_fwd_data_o),
        .mem_req_o       (mem_req_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_paddr_o     (mem_paddr_o),
        .mem_data_o      (mem_data_o),
        .mem_be_o        (mem_be_o),
        .mem_size_o      (mem_size_o),
        .no_st_pending_o (no_st_pending_o),
        .empty_o         (empty_o)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        rst_i = 0; flush_i = 0; st_valid_i = 0; commit_i = 0; ld_valid_i = 0; mem_gnt_i = 0;
        st_paddr_i = '0; st_data_i = '0; st_be_i = '0; st_size_i = '0;
        ld_paddr_i = '0; ld_be_i = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1;
        tick();
        rst_i = 0;
    endtask

    task automatic push(input logic [55:0] a, input logic [63:0] d, input logic [7:0] be);
        st_valid_i = 1; st_paddr_i = a; st_data_i = d; st_be_i = be; st_size_i = 2'd3;
        tick();
        st_valid_i = 0;
    endtask

    task automatic commit1();
        commit_i = 1;
        tick();
        commit_i = 0;
    endtask

    task automatic lookup(input string name, input logic v, input logic [55:0] a, input logic [7:0] be,
                          input logic c, input logic h, input logic [63:0] d);
        ld_valid_i = v; ld_paddr_i = a; ld_be_i = be;
        #1;
        chk({name, "_conflict"}, ld_conflict_o, FWD ? c : (c | h));
        chk({name, "_hit"}, ld_fwd_hit_o, FWD & h);
        chk({name, "_data"}, ld_fwd_data_o, (FWD && h) ? d : 64'h0);
        ld_valid_i = 0;
    endtask

    task automatic chk_reset(input string name);
        #1;
        chk({name, "_st_ready"}, st_ready_o, 1);
        chk({name, "_commit_ready"}, commit_ready_o, 1);
        chk({name, "_mem_req"}, mem_req_o, 0);
        chk({name, "_no_st_pending"}, no_st_pending_o, 1);
        chk({name, "_empty"}, empty_o, 1);
        chk({name, "_conflict"}, ld_conflict_o, 0);
        chk({name, "_hit"}, ld_fwd_hit_o, 0);
        chk({name, "_fwd_data"}, ld_fwd_data_o, 0);
        chk({name, "_mem_paddr"}, mem_paddr_o, 0);
        chk({name, "_mem_data"}, mem_data_o, 0);
        chk({name, "_mem_be"}, mem_be_o, 0);
        chk({name, "_mem_size"}, mem_size_o, 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 56'h2000, 8'h0F, 1'b0, 1'b1, 64'hBBBB_BBBB_BBBB_BBBB};
        vecs[1] = '{1'b1, 56'h2004, 8'hF0, 1'b0, 1'b1, 64'hBBBB_BBBB_BBBB_BBBB};
        vecs[2] = '{1'b1, 56'h2008, 8'hFF, 1'b0, 1'b0, 64'h0};
        vecs[3] = '{1'b1, 56'h3000, 8'hFF, 1'b1, 1'b0, 64'h0};
        vecs[4] = '{1'b0, 56'h2000, 8'h0F, 1'b0, 1'b0, 64'h0};
        vecs[5] = '{1'b1, 56'hA2000, 8'hFF, 1'b1, 1'b0, 64'h0};

        do_reset();
        tick();
        chk_reset("rst");

        // Drain: push, commit, grant held low for three cycles.
        push(56'h1000, 64'h1122_3344_5566_7788, 8'hFF);
        commit_i = 1;
        #1 chk("drain_req_c1", mem_req_o, 0);
        tick();
        commit_i = 0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drain_req_wait%0d", i), mem_req_o, 1);
            chk($sformatf("drain_paddr_wait%0d", i), mem_paddr_o, 56'h1000);
            chk($sformatf("drain_data_wait%0d", i), mem_data_o, 64'h1122_3344_5566_7788);
            tick();
        end
        mem_gnt_i = 1;
        #1 chk("drain_req_gnt", mem_req_o, 1);
        chk("drain_be_gnt", mem_be_o, 8'hFF);
        tick();
        mem_gnt_i = 0;
        #1 chk("drain_no_st_pending", no_st_pending_o, 1);
        chk("drain_req_after", mem_req_o, 0);
        chk("drain_empty", empty_o, 1);

        // Fill, then run push+commit+grant through 3x depth to wrap every pointer.
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("fill_ready%0d", i), st_ready_o, 1);
            push(56'h100 + 56'(8 * i), 64'(i), 8'hFF);
        end
        #1 chk("full_ready", st_ready_o, 0);
        commit1();
        #1 chk("ready_after_commit", st_ready_o, 1);
        for (int i = 4; i < 12; i++) begin
            st_valid_i = 1; st_paddr_i = 56'h100 + 56'(8 * i); st_data_i = 64'(i); st_be_i = 8'hFF;
            commit_i = 1; mem_gnt_i = 1;
            #1 chk($sformatf("wrap_head%0d", i), mem_paddr_o, 56'h100 + 56'(8 * (i - 4)));
            chk($sformatf("wrap_data%0d", i), mem_data_o, 64'(i - 4));
            tick();
        end
        st_valid_i = 0;
        for (int j = 0; j < 3; j++) begin
            #1 chk($sformatf("wrap_tail%0d", j), mem_paddr_o, 56'h100 + 56'(8 * (8 + j)));
            tick();
        end
        commit_i = 0;
        #1 chk("wrap_last", mem_paddr_o, 56'h100 + 56'(8 * 11));
        tick();
        mem_gnt_i = 0;
        #1 chk("wrap_empty", empty_o, 1);

        // Forwarding table against two speculative stores to 0x2000.
        do_reset();
        push(56'h2000, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        push(56'h2000, 64'hBBBB_BBBB_BBBB_BBBB, 8'hFF);
        for (int i = 0; i < 6; i++)
            lookup($sformatf("vec%0d", i), vecs[i].v, vecs[i].addr, vecs[i].be, vecs[i].conf, vecs[i].hit, vecs[i].data);
        commit1();
        lookup("age_across_queues", 1, 56'h2000, 8'h0F, 0, 1, 64'hBBBB_BBBB_BBBB_BBBB);
        push(56'h2000, 64'hCCCC_CCCC_CCCC_CCCC, 8'h01);
        lookup("young_partial", 1, 56'h2000, 8'h0F, 1, 0, 0);
        lookup("young_exact", 1, 56'h2000, 8'h01, 0, 1, 64'hCCCC_CCCC_CCCC_CCCC);
        lookup("skip_nonoverlap", 1, 56'h2000, 8'h02, 0, 1, 64'hBBBB_BBBB_BBBB_BBBB);

        // Conflicts on partial cover and on matching page offset.
        do_reset();
        push(56'h3000, 64'h33, 8'h0F);
        lookup("partial_cover", 1, 56'h3000, 8'hFF, 1, 0, 0);
        lookup("other_offset", 1, 56'h5008, 8'hFF, 0, 0, 0);
        do_reset();
        push(56'h5000, 64'h55, 8'hFF);
        lookup("same_offset", 1, 56'h4000, 8'hFF, 1, 0, 0);
        do_reset();
        st_valid_i = 1; st_paddr_i = 56'h5000; st_data_i = 64'h55; st_be_i = 8'hFF;
        lookup("inflight_push", 1, 56'h5000, 8'hFF, 1, 0, 0);
        st_valid_i = 0;

        // Flush with same-cycle commit and dropped push.
        do_reset();
        push(56'h6000, 64'h60, 8'hFF);
        push(56'h6008, 64'h68, 8'hFF);
        push(56'h6010, 64'h70, 8'hFF);
        flush_i = 1; commit_i = 1;
        st_valid_i = 1; st_paddr_i = 56'h6018; st_data_i = 64'h78; st_be_i = 8'hFF;
        tick();
        idle();
        #1 chk("flush_st_ready", st_ready_o, 1);
        chk("flush_empty", empty_o, 0);
        chk("flush_mem_req", mem_req_o, 1);
        chk("flush_head", mem_paddr_o, 56'h6000);
        lookup("flushed_entry", 1, 56'h6008, 8'hFF, 0, 0, 0);
        lookup("dropped_push", 1, 56'h6018, 8'hFF, 0, 0, 0);
        lookup("committed_entry", 1, 56'h6000, 8'hFF, 0, 1, 64'h60);
        mem_gnt_i = 1;
        tick();
        mem_gnt_i = 0;
        #1 chk("flush_drained", empty_o, 1);
        push(56'h7000, 64'h77, 8'hFF);
        commit1();
        #1 chk("post_flush_paddr", mem_paddr_o, 56'h7000);
        chk("post_flush_data", mem_data_o, 64'h77);
        for (int i = 0; i < 4; i++)
            push(56'h7100 + 56'(8 * i), 64'(i), 8'hFF);
        #1 chk("post_flush_full", st_ready_o, 0);

        // Reset while a drain request is outstanding.
        do_reset();
        push(56'h8000, 64'h88, 8'hF0);
        commit1();
        #1 chk("pre_rst_req", mem_req_o, 1);
        rst_i = 1;
        tick();
        rst_i = 0;
        chk_reset("mid_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_buffer_fwd.md
# store_buffer_fwd

Parametrised two-stage store buffer sitting between the LSU store unit and the D$ request port. Speculative entries are held until commit, then moved to a non-speculative commit FIFO that drains to memory in order. Load lookups return one of two results in the same cycle: a byte-accurate store-to-load forward, or a conflict that stalls the load. This block generalises depth and width. It defines flush/commit coincidence as legal, where the previous generation only asserted against it.

## Interface
Parameters:
- SPEC_DEPTH, 4, speculative entries; power of two, ≥2
- COMMIT_DEPTH, 8, commit entries; power of two, ≥2
- PLEN, 56, physical address width
- XLEN, 64, data width; 32 or 64; BE_W = XLEN/8

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard all speculative entries
- st_valid_i  in  1  push store into speculative queue
- st_ready_o  out  1  speculative queue has space
- st_paddr_i  in  PLEN  store physical address
- st_data_i  in  XLEN  store data, already lane-aligned
- st_be_i  in  BE_W  byte enables
- st_size_i  in  2  access size
- commit_i  in  1  move oldest speculative entry to commit queue
- commit_ready_o  out  1  commit queue has space
- ld_valid_i  in  1  load lookup valid
- ld_paddr_i  in  PLEN  load physical address
- ld_be_i  in  BE_W  load byte enables
- ld_conflict_o  out  1  load must stall
- ld_fwd_hit_o  out  1  forward data valid
- ld_fwd_data_o  out  XLEN  forwarded data
- mem_req_o  out  1  D$ write request
- mem_gnt_i  in  1  D$ grant
- mem_paddr_o  out  PLEN  head address
- mem_data_o  out  XLEN  head data
- mem_be_o  out  BE_W  head byte enables
- mem_size_o  out  2  head size
- no_st_pending_o  out  1  commit queue empty
- empty_o  out  1  both queues empty

## Operation
- Both queues are circular buffers. Each has its own read pointer, write pointer and count. Count width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push is accepted when st_valid_i & st_ready_o. Pushing while st_ready_o=0 is illegal (assertion).
- commit_i copies the speculative head into the commit tail. Both pointers advance in the same cycle.
  - commit_i with an empty speculative queue is illegal.
  - commit_i with commit_ready_o=0 is illegal.
- Drain: mem_req_o = commit count ≠ 0. The mem_* outputs present the head entry and stay stable until mem_gnt_i. On grant, the head pops. rvalid is not used.
- flush_i clears all speculative entries: write pointer := read pointer after any same-cycle commit; count := 0.
  - A same-cycle commit_i still transfers the head.
  - A same-cycle push is dropped.
  - The commit queue is unaffected.
- Same-cycle push + commit, or pop + commit: counts are net-updated (±1 or unchanged).
- Lookup applies only when ld_valid_i=1; otherwise ld_conflict_o=0 and ld_fwd_hit_o=0. Ages rank from oldest to youngest: commit head, commit tail, speculative head, speculative tail.
  - Find the youngest valid entry E with paddr[PLEN-1:3]==ld_paddr_i[PLEN-1:3] and (be & ld_be_i)≠0.
  - Hit: E exists and ld_be_i & ~E.be == 0. Then ld_fwd_hit_o=1, ld_fwd_data_o=E.data, ld_conflict_o=0.
  - Otherwise, ld_conflict_o=1 if any valid entry, or the store being pushed this cycle, matches paddr[11:3].
  - The store being pushed this cycle is never forwarded.
- ld_fwd_data_o=0 whenever ld_fwd_hit_o=0.

## Timing
- Lookup and all status outputs are combinational from registered state plus the ld_*/st_* inputs. Lookup has zero latency.
- st_ready_o = spec count < SPEC_DEPTH. commit_ready_o = commit count < COMMIT_DEPTH. Neither depends combinationally on commit_i or mem_gnt_i.
- Minimum latency from push to mem_req_o:
  - push in cycle 0, commit_i in cycle 1 gives mem_req_o=1 in cycle 2;
  - grant in cycle 2 gives no_st_pending_o=1 in cycle 3.
- Reset (rst_i=1 at a clock edge) clears all valids, pointers and counts, including any request mid-handshake; mem_req_o drops the next cycle.
- Values after reset: st_ready_o=1, commit_ready_o=1, mem_req_o=0, no_st_pending_o=1, empty_o=1, ld_conflict_o=0, ld_fwd_hit_o=0, ld_fwd_data_o=0, mem_paddr_o/data/be/size=0.

## Configuration
- STORE_BUFFER_FWD_EN defined: forwarding as above.
- Undefined: ld_fwd_hit_o=0 and ld_fwd_data_o=0 constantly. ld_conflict_o asserts on any [11:3] match, exactly as for a miss. Forwarding comparators and mux are not built.

## Structure
- ariane_pkg holds:
  - sb_entry_t {paddr, data, be, size, valid}, with parametrised widths via PLEN/XLEN;
  - defaults SB_SPEC_DEPTH and SB_COMMIT_DEPTH.
- One sub-module, sb_fwd_lookup: an age-ordered priority search over the flattened entry vector plus an age rotation index. It produces hit, data and conflict. It is instantiated once.

## Test plan
- Push A=0x1000 (data 0x1122334455667788, be 0xFF); commit; hold mem_gnt_i=0 for 3 cycles, then assert it → mem_req_o high for 4 cycles with stable outputs; no_st_pending_o=1 the cycle after the grant.
- Fill the speculative queue to SPEC_DEPTH → st_ready_o=0; commit 1 → st_ready_o=1 the next cycle; pointers wrap correctly over 3×DEPTH pushes.
- Pushes to 0x2000 with be 0x0F (data ..AA) and be 0xFF (data ..BB); load 0x2000 be 0x0F → hit, data ..BB; then load 0x2004 be 0xF0 → hit, same entry.
- Single store to 0x3000 with be 0x0F; load 0x3000 be 0xFF → ld_conflict_o=1, hit=0. Load 0x5008 → no conflict. Load 0x4000 with a store to 0x5000 → conflict (same offset).
- Three speculative entries plus flush_i+commit_i in the same cycle → commit count +1, spec count 0, empty_o=0 until drained.
- Assert rst_i while mem_req_o=1 → all outputs reach their reset values the next cycle; build without STORE_BUFFER_FWD_EN → scenario 3 yields conflict=1, hit=0.
